// File: rtl/multiplier_acc_pkg.sv
// Shared constants for the shift-add multiply-accumulate. The widths match the
// companion divider so both blocks can be swapped in the same datapath.
package multiplier_acc_pkg;

   localparam int unsigned MUL_WIDTH = 32;
   localparam int unsigned MUL_CNT_W = 5;

   // Number of bits needed to count value distinct states.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned v;
      result = 0;
      if (value > 1) begin
         v = value - 1;
         while (v > 0) begin
            result = result + 1;
            v = v >> 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/multiplier_acc.sv
// Sequential unsigned multiply-accumulate: product = multiplicand * multiplier + addend,
// one multiplier bit per cycle. The addend rides in the high half and is shifted in for free.
module multiplier_acc
   import multiplier_acc_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   addend,
   input  logic               start,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);

   localparam int unsigned     CNT_W = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] reg_a;
   logic [CNT_W-1:0] count;
   logic             busy_d;
   logic [WIDTH:0]   sum;

   // The carry out of the add lands in sum[WIDTH] and is shifted straight into hi.
   always_comb begin
      sum = {1'b0, hi} + (lo[0] ? {1'b0, reg_a} : '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi     <= '0;
         lo     <= '0;
         reg_a  <= '0;
         count  <= '0;
         busy   <= 1'b0;
         busy_d <= 1'b0;
      end else begin
         busy_d <= busy;
         if (start) begin
            hi    <= addend;
            lo    <= multiplier;
            reg_a <= multiplicand;
            count <= '0;
            busy  <= 1'b1;
         end else if (busy) begin
            {hi, lo} <= {sum, lo[WIDTH-1:1]};
            count    <= count + 1'b1;
            if (count == LAST) begin
               busy <= 1'b0;
            end
         end
      end
   end

   assign product = {hi, lo};
   assign done    = ~busy & busy_d;

endmodule

// File: tb/tb_multiplier_acc.sv
// Randomized self-checking bench for multiplier_acc against a plain-arithmetic
// A*B+C reference, covering latency, restart, async reset and idle hold.
module tb_multiplier_acc;

   localparam int unsigned W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic [W-1:0]   addend;
   logic [2*W-1:0] product;
   logic           busy;
   logic           done;

   int             n_cmp = 0;
   int             n_err = 0;
   logic [2*W-1:0] last_exp = '0;

   multiplier_acc #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .addend       (addend),
      .start        (start),
      .product      (product),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_mac(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c);
      logic [2*W-1:0] wa, wb, wc;
      wa = {{W{1'b0}}, a};
      wb = {{W{1'b0}}, b};
      wc = {{W{1'b0}}, c};
      return wa * wb + wc;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start one operation and observe it to completion; operands are scrambled
   // after the load edge since they must only matter at that edge.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input string tag, input int tail);
      logic [2*W-1:0] exp;
      int busy_cnt;
      int done_cnt;
      int lat;
      exp      = ref_mac(a, b, c);
      busy_cnt = 0;
      done_cnt = 0;
      lat      = -1;
      multiplicand = a;
      multiplier   = b;
      addend       = c;
      start        = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < int'(W) + tail; n++) begin
         if (n > 0) tick();
         multiplicand = $urandom;
         multiplier   = $urandom;
         addend       = $urandom;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (lat < 0) lat = n;
         end
      end
      n_cmp++;
      if (product !== exp) begin
         n_err++;
         $display("FAIL %s product: A=%0h B=%0h C=%0h got %0h expected %0h", tag, a, b, c, product, exp);
      end
      n_cmp++;
      if (done_cnt !== 1) begin
         n_err++;
         $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt);
      end
      n_cmp++;
      if (lat !== int'(W)) begin
         n_err++;
         $display("FAIL %s latency: got %0d expected %0d", tag, lat, W);
      end
      n_cmp++;
      if (busy_cnt !== int'(W)) begin
         n_err++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cnt, W);
      end
      last_exp = exp;
   endtask

   task automatic test_reset();
      rst          = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      addend       = '0;
      repeat (3) tick();
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", busy); end
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b expected 0", done); end
      n_cmp++;
      if (product !== '0) begin n_err++; $display("FAIL reset product: got %0h expected 0", product); end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset idle: busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_directed();
      run_op(32'd7, 32'd6, 32'd5, "basic", 8);
      n_cmp++;
      if (last_exp !== 64'h0000_0000_0000_002F) begin
         n_err++;
         $display("FAIL basic model: got %0h expected 2f", last_exp);
      end
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "max", 8);
      n_cmp++;
      if (product !== 64'hFFFF_FFFF_0000_0000) begin
         n_err++;
         $display("FAIL max product: got %0h expected ffffffff00000000", product);
      end
      run_op(32'd14, 32'd7, 32'd2, "div_inverse", 8);
      n_cmp++;
      if (product !== 64'd100) begin
         n_err++;
         $display("FAIL div_inverse product: got %0d expected 100", product);
      end
   endtask

   task automatic test_random_sweep();
      logic [W-1:0] a, b, c;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         b = $urandom;
         c = $urandom;
         case (i % 8)
            0: a = '0;
            1: b = '0;
            2: begin a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15)); end
            3: a = '1;
            4: b = '1;
            default: ;
         endcase
         run_op(a, b, c, "sweep", 2);
      end
   endtask

   task automatic test_restart();
      int done_cnt;
      int lat;
      done_cnt = 0;
      lat      = -1;
      multiplicand = 32'd3;
      multiplier   = 32'd3;
      addend       = 32'd0;
      start        = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n < 10; n++) begin
         tick();
         if (done === 1'b1) done_cnt++;
      end
      multiplicand = 32'd5;
      multiplier   = 32'd5;
      addend       = 32'd1;
      start        = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < int'(W) + 5; n++) begin
         if (n > 0) tick();
         if (done === 1'b1) begin
            done_cnt++;
            if (lat < 0) lat = n;
         end
      end
      n_cmp++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL restart done_count: got %0d expected 1", done_cnt); end
      n_cmp++;
      if (lat !== int'(W)) begin n_err++; $display("FAIL restart latency: got %0d expected %0d", lat, W); end
      n_cmp++;
      if (product !== 64'd26) begin n_err++; $display("FAIL restart product: got %0d expected 26", product); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, c;
      int done_cnt;
      int lat;
      int bad_hold;
      bad_hold = 0;
      done_cnt = 0;
      lat      = -1;
      a = '0; b = '0; c = '0;
      start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         a = $urandom; b = $urandom; c = $urandom;
         multiplicand = a;
         multiplier   = b;
         addend       = c;
         tick();
         if (busy !== 1'b1 || done !== 1'b0) bad_hold++;
      end
      start = 1'b0;
      for (int n = 0; n < int'(W) + 4; n++) begin
         if (n > 0) tick();
         if (done === 1'b1) begin
            done_cnt++;
            if (lat < 0) lat = n;
         end
      end
      n_cmp++;
      if (bad_hold !== 0) begin n_err++; $display("FAIL held_start busy/done: got %0d bad edges expected 0", bad_hold); end
      n_cmp++;
      if (lat !== int'(W) || done_cnt !== 1) begin
         n_err++;
         $display("FAIL held_start done: got latency %0d count %0d expected %0d 1", lat, done_cnt, W);
      end
      n_cmp++;
      if (product !== ref_mac(a, b, c)) begin
         n_err++;
         $display("FAIL held_start product: got %0h expected %0h", product, ref_mac(a, b, c));
      end
   endtask

   task automatic test_reset_mid();
      int stray;
      stray = 0;
      multiplicand = $urandom;
      multiplier   = $urandom | 32'h1;
      addend       = $urandom | 32'h1;
      start        = 1'b1;
      tick();
      start = 1'b0;
      repeat (15) tick();
      #3;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset busy: got %b expected 0", busy); end
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL mid_reset done: got %b expected 0", done); end
      n_cmp++;
      if (product !== '0) begin n_err++; $display("FAIL mid_reset product: got %0h expected 0", product); end
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (busy !== 1'b0 || done !== 1'b0) stray++;
      end
      n_cmp++;
      if (stray !== 0) begin n_err++; $display("FAIL mid_reset idle: got %0d active cycles expected 0", stray); end
      run_op(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, "after_reset", 6);
   endtask

   task automatic test_idle_hold();
      int bad;
      bad = 0;
      run_op($urandom, $urandom, $urandom, "pre_hold", 4);
      for (int n = 0; n < 50; n++) begin
         multiplicand = $urandom;
         multiplier   = $urandom;
         addend       = $urandom;
         tick();
         if (product !== last_exp || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL idle_hold: got %0d disturbed cycles expected 0 (product %0h vs %0h)", bad, product, last_exp);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_restart();
      test_back_to_back();
      test_reset_mid();
      test_idle_hold();
      test_random_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
